// File: rtl/universal_register.sv
`default_nettype none
// ============================================================================
// Module : universal_register
// Brief  : Parametrised register with load, inc/dec (wrap or saturate),
//          logical shifts/rotates with carry-out, zero/ones flags and sticky ovf.
// Rev    : 1.0
// ============================================================================
module universal_register #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SATURATE  = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] D,
  input  logic             shift_in,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] Q,
  output logic             carry,
  output logic             zero,
  output logic             ones,
  output logic             ovf
);

  localparam logic [2:0] c_OP_HOLD = 3'b000;
  localparam logic [2:0] c_OP_LOAD = 3'b001;
  localparam logic [2:0] c_OP_INC  = 3'b010;
  localparam logic [2:0] c_OP_DEC  = 3'b011;
  localparam logic [2:0] c_OP_SHL  = 3'b100;
  localparam logic [2:0] c_OP_SHR  = 3'b101;
  localparam logic [2:0] c_OP_ROL  = 3'b110;
  localparam logic [2:0] c_OP_ROR  = 3'b111;

  localparam logic [WIDTH-1:0] c_ONES = '1;
  localparam logic [WIDTH-1:0] c_ZERO = '0;
  localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic             r_carry;
  logic             w_carry_next;
  logic             r_ovf;
  logic             w_event;
  logic             w_ovf_set;

  always_comb begin
    w_q_next     = r_q;
    w_carry_next = r_carry;
    w_event      = 1'b0;
    case (op)
      c_OP_HOLD: w_q_next = r_q;
      c_OP_LOAD: w_q_next = D;
      c_OP_INC: begin
        if (r_q == c_ONES) begin
          w_event  = 1'b1;
          w_q_next = SATURATE ? c_ONES : c_ZERO;
        end else begin
          w_q_next = r_q + c_ONE;
        end
      end
      c_OP_DEC: begin
        if (r_q == c_ZERO) begin
          w_event  = 1'b1;
          w_q_next = SATURATE ? c_ZERO : c_ONES;
        end else begin
          w_q_next = r_q - c_ONE;
        end
      end
      c_OP_SHL: begin
        w_q_next     = {r_q[WIDTH-2:0], shift_in};
        w_carry_next = r_q[WIDTH-1];
      end
      c_OP_SHR: begin
        w_q_next     = {shift_in, r_q[WIDTH-1:1]};
        w_carry_next = r_q[0];
      end
      c_OP_ROL: begin
        w_q_next     = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_carry_next = r_q[WIDTH-1];
      end
      c_OP_ROR: begin
        w_q_next     = {r_q[0], r_q[WIDTH-1:1]};
        w_carry_next = r_q[0];
      end
      default: begin
        w_q_next     = r_q;
        w_carry_next = r_carry;
      end
    endcase
  end

  // A cleared edge ignores the op, so it can never raise an overflow event.
  assign w_ovf_set = w_event & ~clr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q     <= RESET_VAL;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (clr) begin
        r_q     <= c_ZERO;
        r_carry <= 1'b0;
      end else begin
        r_q     <= w_q_next;
        r_carry <= w_carry_next;
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign Q     = r_q;
  assign carry = r_carry;
  assign ovf   = r_ovf;
  assign zero  = (r_q == c_ZERO);
  assign ones  = (r_q == c_ONES);

endmodule
`default_nettype wire

// File: tb/tb_universal_register.sv
`default_nettype none
// Testbench for universal_register: two 32-bit instances (wrap / saturate)
// sharing stimulus, plus a 4-bit instance; random traffic against a model.
module tb_universal_register;

  typedef struct {
    longint q;
    bit     c;
    bit     o;
  } st_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rst4_n;
  logic        clr, shift_in, ovf_clr;
  logic [2:0]  op;
  logic [31:0] D;
  logic [31:0] Q0, Q1;
  logic        carry0, zero0, ones0, ovf0;
  logic        carry1, zero1, ones1, ovf1;
  logic        clr4, si4, oc4;
  logic [2:0]  op4;
  logic [3:0]  D4, Q4;
  logic        carry4, zero4, ones4, ovf4;

  int checks   = 0;
  int failures = 0;
  st_t m0, m1, m4;

  always #5 clock = ~clock;

  universal_register #(.WIDTH(32), .RESET_VAL(32'd5), .SATURATE(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .clr(clr), .op(op), .D(D),
    .shift_in(shift_in), .ovf_clr(ovf_clr), .Q(Q0), .carry(carry0),
    .zero(zero0), .ones(ones0), .ovf(ovf0));

  universal_register #(.WIDTH(32), .RESET_VAL(32'd5), .SATURATE(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .clr(clr), .op(op), .D(D),
    .shift_in(shift_in), .ovf_clr(ovf_clr), .Q(Q1), .carry(carry1),
    .zero(zero1), .ones(ones1), .ovf(ovf1));

  universal_register #(.WIDTH(4), .RESET_VAL(4'hA), .SATURATE(1'b0)) dut4 (
    .clock(clock), .reset_n(rst4_n), .clr(clr4), .op(op4), .D(D4),
    .shift_in(si4), .ovf_clr(oc4), .Q(Q4), .carry(carry4),
    .zero(zero4), .ones(ones4), .ovf(ovf4));

  // Behavioural reference: one edge of the register, in plain arithmetic.
  function automatic st_t model_step(st_t s, int w, bit sat, bit c_clr, int c_op,
                                     longint d, bit si, bit oc);
    st_t    n;
    longint mx;
    longint top;
    longint half;
    bit     ev;
    n    = s;
    ev   = 1'b0;
    mx   = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    top  = s.q / half;
    if (c_clr) begin
      n.q = 0;
      n.c = 1'b0;
    end else begin
      case (c_op)
        1: n.q = d & mx;
        2: if (s.q == mx) begin ev = 1'b1; n.q = sat ? mx : 0; end
           else n.q = s.q + 1;
        3: if (s.q == 0) begin ev = 1'b1; n.q = sat ? 0 : mx; end
           else n.q = s.q - 1;
        4: begin n.c = bit'(top); n.q = (s.q * 2 + longint'(si)) % (mx + 1); end
        5: begin n.c = bit'(s.q % 2); n.q = s.q / 2 + (si ? half : 0); end
        6: begin n.c = bit'(top); n.q = (s.q * 2) % (mx + 1) + top; end
        7: begin n.c = bit'(s.q % 2); n.q = s.q / 2 + (s.q % 2) * half; end
        default: n.q = s.q;
      endcase
    end
    if (ev) n.o = 1'b1;
    else if (oc) n.o = 1'b0;
    return n;
  endfunction

  task automatic step32(bit c_clr, int c_op, logic [31:0] d, bit si, bit oc);
    clr = c_clr; op = 3'(c_op); D = d; shift_in = si; ovf_clr = oc;
    @(posedge clock);
    m0 = model_step(m0, 32, 1'b0, c_clr, c_op, longint'(d), si, oc);
    m1 = model_step(m1, 32, 1'b1, c_clr, c_op, longint'(d), si, oc);
    #1;
  endtask

  task automatic step4(bit c_clr, int c_op, logic [3:0] d, bit si, bit oc);
    clr4 = c_clr; op4 = 3'(c_op); D4 = d; si4 = si; oc4 = oc;
    @(posedge clock);
    m4 = model_step(m4, 4, 1'b0, c_clr, c_op, longint'(d), si, oc);
    #1;
  endtask

  task automatic test_reset();
    step32(0, 1, 32'h55, 0, 0);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    m0 = '{q: 5, c: 1'b0, o: 1'b0};
    m1 = m0;
    checks++;
    if ({Q0, zero0, ovf0, carry0} !== {32'd5, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_async dut0: got Q=%h z=%b ovf=%b c=%b, want Q=5 z=0 ovf=0 c=0", Q0, zero0, ovf0, carry0);
    end
    checks++;
    if ({Q1, zero1, ovf1} !== {32'd5, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_async dut1: got Q=%h z=%b ovf=%b, want Q=5 z=0 ovf=0", Q1, zero1, ovf1);
    end
    @(negedge clock);
    reset_n = 1'b1;
    step32(0, 2, 32'h0, 0, 0);
    checks++;
    if (Q0 !== 32'd6) begin
      failures++;
      $display("FAIL first_edge_after_reset: got Q=%h, want 6", Q0);
    end
  endtask

  task automatic test_load_hold();
    step32(0, 1, 32'h0000000C, 0, 0);
    checks++;
    if (Q0 !== 32'd12) begin
      failures++;
      $display("FAIL load: got Q=%h, want c", Q0);
    end
    for (int i = 0; i < 3; i++) begin
      step32(0, 0, $urandom, 1, 0);
      checks++;
      if (Q0 !== 32'd12 || Q1 !== 32'd12) begin
        failures++;
        $display("FAIL hold[%0d]: got Q0=%h Q1=%h, want c", i, Q0, Q1);
      end
    end
  endtask

  task automatic test_countdown();
    logic [31:0] exp_q;
    step32(0, 1, 32'd3, 0, 0);
    for (int i = 2; i >= 0; i--) begin
      step32(0, 3, 32'h0, 0, 0);
      exp_q = 32'(i);
      checks++;
      if ({Q0, zero0} !== {exp_q, (i == 0)}) begin
        failures++;
        $display("FAIL countdown dec: got Q=%h z=%b, want Q=%h z=%b", Q0, zero0, exp_q, (i == 0));
      end
    end
    step32(0, 3, 32'h0, 0, 0);
    checks++;
    if ({Q0, ones0, ovf0} !== {32'hFFFFFFFF, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL underflow_wrap: got Q=%h ones=%b ovf=%b, want ffffffff 1 1", Q0, ones0, ovf0);
    end
    checks++;
    if ({Q1, zero1, ovf1} !== {32'h0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL underflow_sat: got Q=%h z=%b ovf=%b, want 0 1 1", Q1, zero1, ovf1);
    end
    step32(0, 0, 32'h0, 0, 1);
    checks++;
    if ({ovf0, ovf1} !== 2'b00) begin
      failures++;
      $display("FAIL ovf_clr_after_underflow: got %b%b, want 00", ovf0, ovf1);
    end
  endtask

  task automatic test_overflow();
    step32(0, 1, 32'hFFFFFFFF, 0, 0);
    step32(0, 2, 32'h0, 0, 0);
    checks++;
    if ({Q0, ovf0, Q1, ovf1} !== {32'h0, 1'b1, 32'hFFFFFFFF, 1'b1}) begin
      failures++;
      $display("FAIL overflow: got Q0=%h ovf0=%b Q1=%h ovf1=%b, want 0 1 ffffffff 1", Q0, ovf0, Q1, ovf1);
    end
    step32(0, 1, 32'hFFFFFFFF, 0, 0);
    step32(0, 2, 32'h0, 0, 1);
    checks++;
    if ({ovf0, ovf1} !== 2'b11) begin
      failures++;
      $display("FAIL ovf_set_wins: got %b%b, want 11", ovf0, ovf1);
    end
    step32(0, 0, 32'h0, 0, 1);
    checks++;
    if ({ovf0, ovf1} !== 2'b00) begin
      failures++;
      $display("FAIL ovf_sticky_clear: got %b%b, want 00", ovf0, ovf1);
    end
  endtask

  task automatic test_shift_rotate();
    logic [32:0] exp_v [4];
    int          ops   [4];
    bit          sis   [4];
    exp_v[0] = {32'h00000002, 1'b1}; ops[0] = 4; sis[0] = 1'b0;
    exp_v[1] = {32'h80000001, 1'b0}; ops[1] = 5; sis[1] = 1'b1;
    exp_v[2] = {32'hC0000000, 1'b1}; ops[2] = 7; sis[2] = 1'b0;
    exp_v[3] = {32'h80000001, 1'b1}; ops[3] = 6; sis[3] = 1'b0;
    step32(0, 1, 32'h80000001, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step32(0, ops[i], 32'h0, sis[i], 0);
      checks++;
      if ({Q0, carry0} !== exp_v[i]) begin
        failures++;
        $display("FAIL shift_rotate op=%0d: got Q=%h c=%b, want %h", ops[i], Q0, carry0, exp_v[i]);
      end
    end
  endtask

  task automatic test_clr_priority();
    step32(0, 1, 32'hFFFFFFFF, 0, 0);
    step32(0, 2, 32'h0, 0, 0);
    step32(0, 1, 32'h891A2B3C, 0, 0);
    step32(0, 4, 32'h0, 0, 0);
    checks++;
    if ({Q0, carry0, ovf0} !== {32'h12345678, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL clr_setup: got Q=%h c=%b ovf=%b, want 12345678 1 1", Q0, carry0, ovf0);
    end
    step32(1, 1, 32'hDEADBEEF, 0, 0);
    checks++;
    if ({Q0, carry0, zero0, ovf0} !== {32'h0, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL clr_priority: got Q=%h c=%b z=%b ovf=%b, want 0 0 1 1", Q0, carry0, zero0, ovf0);
    end
    step32(0, 1, 32'hFFFFFFFF, 0, 1);
    step32(1, 2, 32'h0, 0, 0);
    checks++;
    if ({Q0, ovf0} !== {32'h0, 1'b0}) begin
      failures++;
      $display("FAIL clr_blocks_event: got Q=%h ovf=%b, want 0 0", Q0, ovf0);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    int          sel;
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 3);
      d = (sel == 0) ? 32'hFFFFFFFF : (sel == 1) ? 32'h0 : 32'($urandom);
      step32($urandom_range(0, 15) == 0, $urandom_range(0, 7), d,
             1'($urandom), $urandom_range(0, 3) == 0);
      checks++;
      if ({Q0, carry0, ovf0, zero0, ones0} !==
          {m0.q[31:0], m0.c, m0.o, m0.q == 0, m0.q == 64'hFFFFFFFF}) begin
        failures++;
        $display("FAIL random dut0 cyc=%0d: got Q=%h c=%b ovf=%b, want Q=%h c=%b ovf=%b",
                 i, Q0, carry0, ovf0, m0.q[31:0], m0.c, m0.o);
      end
      checks++;
      if ({Q1, carry1, ovf1, zero1, ones1} !==
          {m1.q[31:0], m1.c, m1.o, m1.q == 0, m1.q == 64'hFFFFFFFF}) begin
        failures++;
        $display("FAIL random dut1 cyc=%0d: got Q=%h c=%b ovf=%b, want Q=%h c=%b ovf=%b",
                 i, Q1, carry1, ovf1, m1.q[31:0], m1.c, m1.o);
      end
    end
  endtask

  task automatic test_width4();
    logic [3:0] exp_q;
    clr = 1'b0; op = 3'd0; ovf_clr = 1'b0;
    rst4_n = 1'b0;
    #2;
    m4 = '{q: 10, c: 1'b0, o: 1'b0};
    checks++;
    if ({Q4, ovf4} !== {4'hA, 1'b0}) begin
      failures++;
      $display("FAIL w4_reset: got Q=%h ovf=%b, want a 0", Q4, ovf4);
    end
    @(negedge clock);
    rst4_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step4(0, 2, 4'h0, 0, 0);
      exp_q = 4'(11 + i);
      checks++;
      if ({Q4, ovf4} !== {exp_q, (i == 5)}) begin
        failures++;
        $display("FAIL w4_inc[%0d]: got Q=%h ovf=%b, want %h %b", i, Q4, ovf4, exp_q, (i == 5));
      end
    end
    step4(0, 1, 4'hF, 0, 0);
    step4(0, 4, 4'h0, 1, 0);
    checks++;
    if ({Q4, carry4, ones4, ovf4} !== {4'hF, 1'b1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL w4_shl: got Q=%h c=%b ones=%b ovf=%b, want f 1 1 1", Q4, carry4, ones4, ovf4);
    end
    for (int i = 0; i < 100; i++) begin
      step4($urandom_range(0, 15) == 0, $urandom_range(0, 7), 4'($urandom),
            1'($urandom), $urandom_range(0, 3) == 0);
      checks++;
      if ({Q4, carry4, ovf4, zero4, ones4} !==
          {m4.q[3:0], m4.c, m4.o, m4.q == 0, m4.q == 15}) begin
        failures++;
        $display("FAIL w4_random cyc=%0d: got Q=%h c=%b ovf=%b, want Q=%h c=%b ovf=%b",
                 i, Q4, carry4, ovf4, m4.q[3:0], m4.c, m4.o);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; rst4_n = 1'b0;
    clr = 1'b0; op = 3'd0; D = '0; shift_in = 1'b0; ovf_clr = 1'b0;
    clr4 = 1'b0; op4 = 3'd0; D4 = '0; si4 = 1'b0; oc4 = 1'b0;
    m0 = '{q: 5, c: 1'b0, o: 1'b0};
    m1 = m0;
    m4 = '{q: 10, c: 1'b0, o: 1'b0};
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1; rst4_n = 1'b1;
    test_reset();
    test_load_hold();
    test_countdown();
    test_overflow();
    test_shift_rotate();
    test_clr_priority();
    test_random();
    test_width4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
